mat3_vec_dot_seq: RTL and testbench
===================================

# mat3_vec_dot_seq

Sequential 3x3-matrix by 3-vector multiplier for the fixed-point transform path. It sits directly upstream of the team's combinational 3-element fixed-point dot unit and time-multiplexes that unit across the three matrix rows. Each cycle it drives one row and the vector into the unit, then captures the unit's product into one lane of the result vector. Typical uses are camera/view transforms and normal rotation ahead of rasterization.

## Interface
- A_WIDTH, 16, width of matrix elements (dot-unit A operand)
- A_FRAC_BITS, 14, fractional bits of matrix elements
- B_WIDTH, 16, width of vector elements (dot-unit B operand)
- B_FRAC_BITS, 14, fractional bits of vector elements
- P_WIDTH, 16, width of dot-unit product and of each result lane
- P_FRAC_BITS, 14, fractional bits of product; informational only, no rescaling here
- clk_in  input  1  single clock
- rst_in  input  1  synchronous, active-high reset
- valid_in  input  1  upstream offers M_in/v_in
- ready_out  output  1  block can accept a job
- M_in  input  [2:0][2:0][A_WIDTH-1:0] signed  matrix, M_in[r] = row r
- v_in  input  [2:0][B_WIDTH-1:0] signed  vector
- dot_a_out  output  [2:0][A_WIDTH-1:0] signed  row to dot unit
- dot_b_out  output  [2:0][B_WIDTH-1:0] signed  vector to dot unit
- dot_p_in  input  [P_WIDTH-1:0] signed  dot-unit product (combinational from dot_a_out/dot_b_out)
- valid_out  output  1  result available
- ready_in  input  1  downstream accepts result
- result_out  output  [2:0][P_WIDTH-1:0] signed  result_out[r] = row r · v

## Operation
- States: IDLE, ISSUE, DONE. A 2-bit row counter `row` runs 0..2.
- IDLE: ready_out=1. On valid_in && ready_out:
  - latch M_in and v_in;
  - set row=0;
  - go to ISSUE.
- ISSUE: ready_out=0.
  - dot_a_out = latched M[row]; dot_b_out = latched v.
  - The captured dot_p_in is written to result_out[capture row].
  - After the last capture (row 2), go to DONE.
- DONE: valid_out=1 and result_out is stable. On ready_in, go to IDLE. There is no same-cycle accept of a new job in DONE.
- dot_a_out and dot_b_out are 0 in IDLE and DONE.
- Arithmetic: pass-through only. Each lane is dot_p_in exactly, with no shift, saturation or sign extension. Width and precision are owned by the dot unit.
- result_out retains its last values after the DONE handshake until overwritten by the next job.
- Inputs are ignored outside IDLE. Changes to M_in/v_in after the handshake do not affect the job in flight.

## Timing
- Reset: state=IDLE, row=0, ready_out=1, valid_out=0, result_out all lanes 0, dot_a_out=0, dot_b_out=0. Reset mid-job abandons the job with no partial valid_out.
- Handshake at edge T (macro off):
  - rows 0, 1, 2 are issued in cycles T+1, T+2, T+3 and captured at the end of each of those cycles;
  - valid_out=1 from T+4;
  - latency is 4 cycles, accept to valid.
- DONE exit: if valid_out && ready_in at edge D, then ready_out=1 in cycle D+1. Minimum job interval is 5 cycles (6 with macro).
- Backpressure: valid_out and result_out are held indefinitely while ready_in=0.
- ready_in is ignored when valid_out=0.

## Configuration
- MAT3_VEC_DOT_SEQ_REG_PRODUCT_EN:
  - Defined: dot_p_in is registered before capture, which breaks the combinational loop through the dot unit.
    - Rows are still issued in T+1..T+3.
    - Captures happen at the end of T+2..T+4, into lane row-1 (delayed index).
    - ISSUE lasts 4 cycles, with dot_a_out=0 in the final cycle.
    - valid_out rises at T+5.
  - Undefined: direct capture as described in Timing, latency 4.

## Test plan
- Identity test: M=I (16384 on the diagonal, Q2.14) and v=(16384, 8192, -4096), with a bench dot model (product >>>14). Required response:
  - valid_out at T+4;
  - result_out=(16384, 8192, -4096);
  - dot_a_out sequence equals rows 0, 1, 2.
- Row distinctness: M rows (8192,0,0), (0,-16384,0), (4096,4096,4096) and v=(16384,16384,16384). Required response: result=(8192, -16384, 12288).
- Backpressure: ready_in=0 for 6 cycles after valid_out. Required response:
  - valid_out and result_out are stable;
  - ready_out=0;
  - a valid_in pulse during that window is not accepted;
  - after ready_in=1, ready_out returns the next cycle.
- Back-to-back: valid_in held high with two different jobs. Required response: accepts are 5 cycles apart and both results are correct and in order.
- Reset mid-job: assert rst_in at T+2 for 1 cycle. Required response:
  - valid_out is never asserted for that job;
  - result_out=0;
  - ready_out=1 the cycle after reset.
- Macro build: repeat the identity test. Required response: valid_out at T+5 with identical results.

Source files
------------

// File: rtl/mat3_vec_dot_seq_if.sv
// rtl/mat3_vec_dot_seq_if.sv - job, result and dot-unit signal bundle for mat3_vec_dot_seq
interface mat3_vec_dot_seq_if #(
  parameter int A_WIDTH = 16,
  parameter int B_WIDTH = 16,
  parameter int P_WIDTH = 16
);
  logic                                valid_in;
  logic                                ready_out;
  logic signed [2:0][2:0][A_WIDTH-1:0] M_in;
  logic signed [2:0][B_WIDTH-1:0]      v_in;
  logic signed [2:0][A_WIDTH-1:0]      dot_a_out;
  logic signed [2:0][B_WIDTH-1:0]      dot_b_out;
  logic signed [P_WIDTH-1:0]           dot_p_in;
  logic                                valid_out;
  logic                                ready_in;
  logic signed [2:0][P_WIDTH-1:0]      result_out;

  modport slave (
    input  valid_in, M_in, v_in, dot_p_in, ready_in,
    output ready_out, dot_a_out, dot_b_out, valid_out, result_out
  );

  modport master (
    output valid_in, M_in, v_in, dot_p_in, ready_in,
    input  ready_out, dot_a_out, dot_b_out, valid_out, result_out
  );
endinterface

// File: rtl/mat3_vec_dot_seq.sv
// rtl/mat3_vec_dot_seq.sv - 3x3 matrix by vector multiplier sharing one dot unit over three rows (option: MAT3_VEC_DOT_SEQ_REG_PRODUCT_EN)
module mat3_vec_dot_seq #(
  parameter int A_WIDTH     = 16,
  parameter int A_FRAC_BITS = 14,
  parameter int B_WIDTH     = 16,
  parameter int B_FRAC_BITS = 14,
  parameter int P_WIDTH     = 16,
  parameter int P_FRAC_BITS = 14
) (
  input  logic               clk_in,
  input  logic               rst_in,
  mat3_vec_dot_seq_if.slave  bus
);

  // Fixed-point layout is owned by the dot unit; only sanity-check it here.
  if (A_FRAC_BITS > A_WIDTH || B_FRAC_BITS > B_WIDTH || P_FRAC_BITS > P_WIDTH) begin : g_bad_frac
    $error("fractional bits exceed operand width");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                              state_q, state_d;
  logic [1:0]                          row_q, row_d;
  logic signed [2:0][2:0][A_WIDTH-1:0] m_q;
  logic signed [2:0][B_WIDTH-1:0]      v_q;
  logic signed [2:0][P_WIDTH-1:0]      res_q;
  logic                                accept;
  logic                                capture_en;
  logic [1:0]                          capture_row;
  logic [P_WIDTH-1:0]                  capture_val;

`ifdef MAT3_VEC_DOT_SEQ_REG_PRODUCT_EN
  // One extra ISSUE cycle drains the product register into lane 2.
  localparam logic [1:0] LAST_ROW = 2'd3;
  logic [P_WIDTH-1:0] p_q;

  // Product register: breaks the loop through the external dot unit.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      p_q <= '0;
    end else begin
      p_q <= bus.dot_p_in;
    end
  end

  assign capture_en  = (state_q == ISSUE) && (row_q != 2'd0);
  assign capture_row = row_q - 2'd1;
  assign capture_val = p_q;
`else
  localparam logic [1:0] LAST_ROW = 2'd2;

  assign capture_en  = (state_q == ISSUE);
  assign capture_row = row_q;
  assign capture_val = bus.dot_p_in;
`endif

  assign accept         = (state_q == IDLE) && bus.valid_in;
  assign bus.result_out = res_q;

  // State and row counter registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      row_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  // Next state, row sequencing and handshake/dot-unit drive.
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    bus.ready_out = 1'b0;
    bus.valid_out = 1'b0;
    bus.dot_a_out = '0;
    bus.dot_b_out = '0;
    case (state_q)
      IDLE: begin
        bus.ready_out = 1'b1;
        if (bus.valid_in) begin
          state_d = ISSUE;
          row_d   = 2'd0;
        end
      end
      ISSUE: begin
        if (row_q <= 2'd2) begin
          bus.dot_a_out = m_q[row_q];
        end
        bus.dot_b_out = v_q;
        row_d         = row_q + 2'd1;
        if (row_q == LAST_ROW) begin
          state_d = DONE;
          row_d   = 2'd0;
        end
      end
      DONE: begin
        bus.valid_out = 1'b1;
        if (bus.ready_in) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        row_d   = 2'd0;
      end
    endcase
  end

  // Job operands are snapshotted at accept so later input changes cannot leak in.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      m_q <= '0;
      v_q <= '0;
    end else if (accept) begin
      m_q <= bus.M_in;
      v_q <= bus.v_in;
    end
  end

  // Result lanes: dot-unit product passed through unchanged into the capture lane.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      res_q <= '0;
    end else if (capture_en) begin
      res_q[capture_row] <= capture_val;
    end
  end

endmodule

// File: tb/tb_mat3_vec_dot_seq.sv
// tb/tb_mat3_vec_dot_seq.sv - self-checking bench for mat3_vec_dot_seq
module tb_mat3_vec_dot_seq;
  localparam int AW = 16;
  localparam int BW = 16;
  localparam int PW = 16;
`ifdef MAT3_VEC_DOT_SEQ_REG_PRODUCT_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  typedef logic [2:0][AW-1:0]      row_t;
  typedef logic [2:0][2:0][AW-1:0] mat_t;
  typedef logic [2:0][BW-1:0]      vec_t;
  typedef logic [2:0][PW-1:0]      res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  mat3_vec_dot_seq_if #(.A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW)) bus ();

  mat3_vec_dot_seq #(
    .A_WIDTH(AW), .A_FRAC_BITS(14), .B_WIDTH(BW), .B_FRAC_BITS(14),
    .P_WIDTH(PW), .P_FRAC_BITS(14)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Q2.14 dot unit: full-precision sum of products, arithmetic shift by 14, truncate.
  function automatic logic [PW-1:0] dotf(input row_t a, input vec_t b);
    longint s;
    s = 0;
    for (int i = 0; i < 3; i++) begin
      s = s + longint'($signed(a[i])) * longint'($signed(b[i]));
    end
    s = s >>> 14;
    return s[PW-1:0];
  endfunction

  assign bus.dot_p_in = dotf(bus.dot_a_out, bus.dot_b_out);

  function automatic res_t mulres(input mat_t m, input vec_t v);
    res_t r;
    for (int i = 0; i < 3; i++) r[i] = dotf(m[i], v);
    return r;
  endfunction

  function automatic row_t mkrow(input int a0, input int a1, input int a2);
    row_t r;
    r[0] = a0[AW-1:0];
    r[1] = a1[AW-1:0];
    r[2] = a2[AW-1:0];
    return r;
  endfunction

  function automatic vec_t mkvec(input int a0, input int a1, input int a2);
    vec_t r;
    r[0] = a0[BW-1:0];
    r[1] = a1[BW-1:0];
    r[2] = a2[BW-1:0];
    return r;
  endfunction

  function automatic res_t mkres(input int a0, input int a1, input int a2);
    res_t r;
    r[0] = a0[PW-1:0];
    r[1] = a1[PW-1:0];
    r[2] = a2[PW-1:0];
    return r;
  endfunction

  function automatic mat_t mkmat(input row_t r0, input row_t r1, input row_t r2);
    mat_t m;
    m[0] = r0;
    m[1] = r1;
    m[2] = r2;
    return m;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model state: ph counts cycles since accept (0 = idle, LAT = result held).
  bit    chk_en = 1'b0;
  int    ph = 0;
  mat_t  job_m;
  vec_t  job_v;
  res_t  job_res;
  res_t  last_res = '0;
  row_t  exp_a;
  vec_t  exp_b;
  row_t  seen_a [3];
  logic  prev_valid = 1'b0;
  int    vcount = 0;
  int    vrise_cyc = 0;
  int    acc_cyc [$];
  res_t  vres_q [$];

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("ready_out", 64'(bus.ready_out), 64'(ph == 0));
        chk("valid_out", 64'(bus.valid_out), 64'(ph == LAT));
        exp_a = '0;
        exp_b = '0;
        if (ph >= 1 && ph <= 3) exp_a = job_m[ph-1];
        if (ph >= 1 && ph < LAT) exp_b = job_v;
        chk("dot_a_out", 64'(row_t'(bus.dot_a_out)), 64'(exp_a));
        chk("dot_b_out", 64'(vec_t'(bus.dot_b_out)), 64'(exp_b));
        if (ph >= 1 && ph <= 3) seen_a[ph-1] = bus.dot_a_out;
        if (ph == 0) chk("result_idle", 64'(res_t'(bus.result_out)), 64'(last_res));
        if (ph == LAT) chk("result_done", 64'(res_t'(bus.result_out)), 64'(job_res));
        if (bus.valid_out && !prev_valid) begin
          vcount++;
          vrise_cyc = cyc;
          vres_q.push_back(bus.result_out);
        end
        prev_valid = bus.valid_out;
        if (rst) begin
          ph = 0;
          last_res = '0;
        end else if (ph == 0) begin
          if (bus.valid_in) begin
            job_m = bus.M_in;
            job_v = bus.v_in;
            job_res = mulres(job_m, job_v);
            ph = 1;
            acc_cyc.push_back(cyc);
          end
        end else if (ph < LAT) begin
          ph++;
        end else if (bus.ready_in) begin
          last_res = job_res;
          ph = 0;
        end
      end
    end
  end

  task automatic start_job(input mat_t m, input vec_t v);
    int n;
    n = 0;
    @(posedge clk); #1;
    bus.M_in = m;
    bus.v_in = v;
    bus.valid_in = 1'b1;
    @(negedge clk);
    while (!bus.ready_out && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready_out) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.valid_out && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!bus.valid_out) chk("valid_timeout", 64'd0, 64'd1);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.ready_out && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready_out) chk("ready_timeout", 64'd0, 64'd1);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  mat_t m_id, m_rows;
  int   acc_before, vc0;

  initial begin
    m_id   = mkmat(mkrow(16384, 0, 0), mkrow(0, 16384, 0), mkrow(0, 0, 16384));
    m_rows = mkmat(mkrow(8192, 0, 0), mkrow(0, -16384, 0), mkrow(4096, 4096, 4096));
    bus.valid_in = 1'b0;
    bus.M_in = '0;
    bus.v_in = '0;
    bus.ready_in = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(bus.ready_out), 64'd1);
    chk("rst_valid", 64'(bus.valid_out), 64'd0);
    chk("rst_result", 64'(res_t'(bus.result_out)), 64'd0);
    chk("rst_dot_a", 64'(row_t'(bus.dot_a_out)), 64'd0);

    // Identity matrix
    start_job(m_id, mkvec(16384, 8192, -4096));
    wait_valid();
    chk("id_latency", 64'(vrise_cyc - acc_cyc[acc_cyc.size()-1]), 64'(LAT));
    chk("id_result", 64'(vres_q[vres_q.size()-1]), 64'(mkres(16384, 8192, -4096)));
    chk("id_row0", 64'(seen_a[0]), 64'(mkrow(16384, 0, 0)));
    chk("id_row1", 64'(seen_a[1]), 64'(mkrow(0, 16384, 0)));
    chk("id_row2", 64'(seen_a[2]), 64'(mkrow(0, 0, 16384)));
    wait_ready();

    // Distinct rows
    start_job(m_rows, mkvec(16384, 16384, 16384));
    wait_valid();
    chk("rows_result", 64'(vres_q[vres_q.size()-1]), 64'(mkres(8192, -16384, 12288)));
    wait_ready();

    // Backpressure with a stray valid_in pulse while the result is held
    bus.ready_in = 1'b0;
    start_job(m_id, mkvec(100, -200, 300));
    wait_valid();
    acc_before = acc_cyc.size();
    bus.M_in = m_rows;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      bus.valid_in = (i == 2);
    end
    chk("bp_no_accept", 64'(acc_cyc.size()), 64'(acc_before));
    chk("bp_valid_held", 64'(bus.valid_out), 64'd1);
    chk("bp_ready_low", 64'(bus.ready_out), 64'd0);
    chk("bp_result", 64'(res_t'(bus.result_out)), 64'(mkres(100, -200, 300)));
    bus.ready_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_ready_return", 64'(bus.ready_out), 64'd1);

    // Back-to-back with valid_in held high
    @(posedge clk); #1;
    bus.M_in = m_id;
    bus.v_in = mkvec(1000, 2000, 3000);
    bus.valid_in = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    bus.M_in = m_rows;
    bus.v_in = mkvec(16384, 16384, 16384);
    wait_ready();
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    wait_valid();
    chk("b2b_interval", 64'(acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2]), 64'(LAT + 1));
    chk("b2b_res1", 64'(vres_q[vres_q.size()-2]), 64'(mkres(1000, 2000, 3000)));
    chk("b2b_res2", 64'(vres_q[vres_q.size()-1]), 64'(mkres(8192, -16384, 12288)));
    wait_ready();

    // Reset in the middle of a job
    vc0 = vcount;
    start_job(m_id, mkvec(7, 8, 9));
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", 64'(bus.ready_out), 64'd1);
    chk("rst_mid_result", 64'(res_t'(bus.result_out)), 64'd0);
    repeat (8) @(negedge clk);
    chk("rst_mid_no_valid", 64'(vcount), 64'(vc0));

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
